cache_bus_arbiter: RTL
======================

Name: cache_bus_arbiter

Overview:
- Shares the single RAM port among four cache requesters: core0/core1 icache and core0/core1 dcache.
- Sits between the per-core cache_control_if ports and the RAM.
- Holds the grant across multi-word dcache transactions: 2-word fill, 2-word writeback, writeback followed by fill, and flush sequences.
- Priority: dcache over icache; round-robin within each class; a burst cap bounds starvation.

Parameters:
- CPUS, 2, number of cores (fixed at 2 for this revision).
- MAX_BURST, 8, max RAM ACCESS completions per grant before forced release, applied only when another requester is waiting.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  synchronous, active-low reset, sampled on posedge CLK.
- iREN  in  [1:0]  icache read request, per core.
- iaddr  in  [1:0]x32  icache address, per core.
- iwait  out  [1:0]  icache wait, per core; 0 = data valid this cycle.
- iload  out  [1:0]x32  icache read data, per core.
- dREN  in  [1:0]  dcache read request, per core.
- dWEN  in  [1:0]  dcache write request, per core.
- daddr  in  [1:0]x32  dcache address, per core.
- dstore  in  [1:0]x32  dcache write data, per core.
- dwait  out  [1:0]  dcache wait, per core.
- dload  out  [1:0]x32  dcache read data, per core.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Behaviour:
- Requester IDs: 0=d0, 1=d1, 2=i0, 3=i1. req[k] = dREN|dWEN for k<2, iREN for k>=2.
- States:
  - ARB: no grant.
  - SERVE: grant register gnt_id valid.
- Reset (nRST low at posedge):
  - state=ARB; gnt_id=0; rr_d=0; rr_i=0; burst_cnt=0.
  - All waits=1; ram enables=0; ramaddr/ramstore=0; loads=0.
- ARB:
  - If any dcache req: pick by rr_d (rr_d=0 prefers d0, else d1; if only one requests, take it).
  - Else if any icache req: pick by rr_i, same rule.
  - Register gnt_id, go to SERVE next cycle. Latency: request at cycle N, RAM enables driven at N+1.
  - No req: stay in ARB.
- SERVE, combinational muxing from gnt_id:
  - ramREN = granted REN. ramWEN = granted dWEN (icache: 0).
  - If the dcache drives both dREN and dWEN: WEN wins, REN=0.
  - ramaddr/ramstore = granted addr/store; ramstore=0 for icache.
  - Granted wait = ~(ramstate==ACCESS). All other waits=1.
  - Granted load = ramload; all other loads=0.
- BUSY and ERROR are both treated as not-done: wait stays 1, no retry logic. The request stays asserted.
- Each ACCESS cycle: burst_cnt <= burst_cnt+1, saturating at MAX_BURST.
- Release (next state ARB; burst_cnt<=0; the rr pointer of the served class toggles to the other core):
  - (a) granted req deasserts in SERVE; or
  - (b) an ACCESS cycle completes with burst_cnt+1 == MAX_BURST while any other req is high.
- Release does not fire on an REN/WEN switch: a dcache going WEN→REN with req continuously high keeps the grant.
- Forced release (b) takes effect after the ACCESS cycle, so no access is ever split.
- ARB always lasts exactly 1 cycle between grants; back-to-back transactions pay 1 cycle of arbitration.
- Simultaneous events:
  - All four requesting: d-class is served round-robin until neither dcache requests; icache is served only then.
  - Requester raises req in the same cycle another's grant releases: seen in ARB next cycle.
- Reset mid-SERVE: grant dropped immediately, enables 0 next cycle; the RAM transaction is abandoned.

Optional Feature:
- Macro: CACHE_BUS_ARBITER_PERF_EN.
- With it:
  - Extra outputs perf_grants [3:0]x32 (count of SERVE entries per requester) and perf_stall [3:0]x32 (count of cycles the requester's req=1 while not granted, or granted with ramstate!=ACCESS).
  - Counters wrap at 2^32 and are synchronously cleared by nRST.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t; reuse them.
- New in cache_pkg:
  - arb_state_t {ARB, SERVE}.
  - req_id_t (2 bits), with constants REQ_D0, REQ_D1, REQ_I0, REQ_I1.
  - ARB_MAX_BURST_W, width of burst_cnt.
- One sub-module: rr_pick2 (inputs req[1:0], ptr; outputs any, sel). Instantiated twice, for the d-class and the i-class.

Test Plan:
- Reset: nRST=0 for 2 cycles with all reqs high → all waits=1, ramREN=ramWEN=0; after release, first grant is d0 at the 2nd posedge.
- Single icache: iREN[0]=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004 → iwait[0]=0 for exactly 1 cycle, iload[0]=0x8C010004.
- Writeback+fill: d1 holds dWEN for 2 ACCESS (addrs 0x1000,0x1004), then dREN for 2 ACCESS with req continuously high while iREN[0]=1 → grant stays d1 throughout; i0 granted only after dREN[1] drops.
- Round-robin: d0 and d1 both issue repeated single reads → grants alternate d0,d1,d0,d1 with 1 ARB cycle between each.
- Burst cap: MAX_BURST=8, d0 holds dREN for 20 ACCESS while d1 requests → d0 released after its 8th ACCESS, d1 served, d0 regranted after.
- Perf (CACHE_BUS_ARBITER_PERF_EN): i1 requests for 5 cycles while d0 is served → perf_stall[3]=5 and perf_grants[0]=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Cache-side shared types for the bus arbiter: FSM states, requester ids, burst counter sizing.
package cache_pkg;

    typedef enum logic {
        ARB,
        SERVE
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_D0 = 2'd0;
    localparam req_id_t REQ_D1 = 2'd1;
    localparam req_id_t REQ_I0 = 2'd2;
    localparam req_id_t REQ_I1 = 2'd3;

    localparam int ARB_MAX_BURST   = 8;
    localparam int ARB_MAX_BURST_W = $clog2(ARB_MAX_BURST + 1);

endpackage

// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types: the machine word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: ptr chooses only when both requesters contend.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       any,
    output logic       sel
);

    assign any = |req;
    assign sel = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one RAM port among two icaches and two dcaches; dcache first, round-robin per class.
// Optional CACHE_BUS_ARBITER_PERF_EN adds per-requester grant and stall counters.
module cache_bus_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  word_t [CPUS-1:0]     iaddr,
    output logic [CPUS-1:0]      iwait,
    output word_t [CPUS-1:0]     iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
`ifdef CACHE_BUS_ARBITER_PERF_EN
    ,
    output word_t [3:0]          perf_grants,
    output word_t [3:0]          perf_stall
`endif
);

    // MAX_BURST must fit the package-sized counter (at most ARB_MAX_BURST).
    localparam int CNT_W = ARB_MAX_BURST_W;
    localparam logic [CNT_W:0] BURST_LIMIT = (CNT_W + 1)'(MAX_BURST);

    arb_state_t         state;
    req_id_t            gnt_id;
    logic               rr_d;
    logic               rr_i;
    logic [CNT_W-1:0]   burst_cnt;

    logic [3:0]         req;
    logic               d_any, d_sel, i_any, i_sel;
    req_id_t            pick_id;
    logic               gnt_core;
    logic               others_req;
    logic [CNT_W:0]     burst_next;
    logic               is_access;
    logic               release_now;

    assign req        = {iREN, dREN | dWEN};
    assign gnt_core   = gnt_id[0];
    assign is_access  = (ramstate == ACCESS);
    assign others_req = |(req & ~(4'b0001 << gnt_id));
    assign burst_next = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign pick_id    = d_any ? (d_sel ? REQ_D1 : REQ_D0) : (i_sel ? REQ_I1 : REQ_I0);

    // The cap only releases after a completed access, so no transfer is ever split.
    assign release_now = (state == SERVE) &&
                         (!req[gnt_id] || (is_access && (burst_next >= BURST_LIMIT) && others_req));

    rr_pick2 u_pick_d (
        .req (req[1:0]),
        .ptr (rr_d),
        .any (d_any),
        .sel (d_sel)
    );

    rr_pick2 u_pick_i (
        .req (req[3:2]),
        .ptr (rr_i),
        .any (i_any),
        .sel (i_sel)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= ARB;
            gnt_id    <= REQ_D0;
            rr_d      <= 1'b0;
            rr_i      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    burst_cnt <= '0;
                    if (d_any || i_any) begin
                        gnt_id <= pick_id;
                        state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (release_now) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                        if (gnt_id[1]) begin
                            rr_i <= ~gnt_core;
                        end else begin
                            rr_d <= ~gnt_core;
                        end
                    end else if (is_access && (burst_next <= BURST_LIMIT)) begin
                        burst_cnt <= burst_next[CNT_W-1:0];
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // A dcache asserting both enables is treated as a write.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == SERVE) begin
            if (gnt_id[1]) begin
                ramREN          = iREN[gnt_core];
                ramaddr         = iaddr[gnt_core];
                iwait[gnt_core] = ~is_access;
                iload[gnt_core] = ramload;
            end else begin
                ramWEN          = dWEN[gnt_core];
                ramREN          = dREN[gnt_core] & ~dWEN[gnt_core];
                ramaddr         = daddr[gnt_core];
                ramstore        = dstore[gnt_core];
                dwait[gnt_core] = ~is_access;
                dload[gnt_core] = ramload;
            end
        end
    end

`ifdef CACHE_BUS_ARBITER_PERF_EN
    // A requester stalls whenever it asks and is not completing an access this cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if ((state == ARB) && (d_any || i_any) && (pick_id == req_id_t'(k))) begin
                    perf_grants[k] <= perf_grants[k] + 32'd1;
                end
                if (req[k] && !((state == SERVE) && (gnt_id == req_id_t'(k)) && is_access)) begin
                    perf_stall[k] <= perf_stall[k] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
